hann32_apply: RTL and testbench
===============================

// Module: hann32_apply
// PURPOSE
//  Applies the 32-point Hann window to a framed stream of signed samples: out = round(x[k]*w[k]/2048).
//  Uses the same 12-bit Q1.11 coefficient table as the hann32 coefficient generator (w[16]=2048=1.0).
//  Sits between the sample capture path and the FFT input.
//  Valid/ready on both sides; 2-stage pipeline with full-throughput backpressure.
// PARAMETERS
//  DATA_W   12  width of signed input/output samples (two's complement)
//  N        32  frame length; localparam, not overridable
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_data    in   DATA_W  signed input sample
//  in_valid   in   1       in_data/in_sof valid
//  in_sof     in   1       first sample of a frame (index forced to 0)
//  in_ready   out  1       block accepts a sample this cycle
//  out_data   out  DATA_W  signed windowed sample
//  out_valid  out  1       out_* valid
//  out_sof    out  1       out_data is frame index 0
//  out_last   out  1       out_data is frame index 31
//  out_ready  in   1       downstream accepts out_* this cycle
//  frame_err  out  1       1-cycle pulse: in_sof accepted while index != 0
// BEHAVIOUR
//  Reset (rst_n=0, async): idx=0, both stage-valid flags=0, out_valid=0, out_data=0,
//   out_sof=0, out_last=0, frame_err=0. All pipeline data is discarded.
//  Handshake:
//   - Transfer on a side occurs when valid&&ready.
//   - adv = !out_valid || out_ready; in_ready = adv (combinational).
//   - Both stages move only when adv=1.
//   - out_* must be held stable while out_valid && !out_ready.
//  Index counter idx[4:0] advances on each accepted input.
//   - in_sof=1: sample uses index 0 and idx becomes 1.
//   - Otherwise the sample uses idx, and idx <= idx+1, wrapping 31->0.
//  frame_err pulses one cycle after an accepted in_sof with idx != 0; the resync still happens.
//  Coefficient table w[k] (k=0..31), symmetric w[k]=w[32-k]:
//   k:  0  1   2   3   4   5   6   7   8    9    10   11   12   13   14   15   16
//   w:  0  20  78  173 300 455 632 824 1024 1224 1416 1593 1748 1875 1970 2028 2048
//  Stage 1 (on adv): register x, w[index], sof=(index==0), last=(index==31), valid=in_valid.
//  Stage 2 (on adv):
//   - p = $signed(x) * $signed({1'b0,w}); full 2*DATA_W+1 bit product.
//   - out_data = (p + 1024) >>> 11, an arithmetic shift (round half toward +inf).
//   - No saturation is needed (|w| <= 1.0). out_sof, out_last and out_valid follow stage 1.
//  Latency: accepted input appears on out_* 2 cycles later when out_ready is held 1.
//   Throughput is 1 sample/cycle.
//  out_ready=0 with out_valid=1 stalls both stages and drops in_ready.
//   Stage 1 and idx are held; no sample is lost or duplicated.
//  Bubbles (in_valid=0) propagate as out_valid=0 and do not advance idx.
//  in_data/in_sof are ignored when in_valid=0 or in_ready=0.
// TESTING
//  1. Reset then 32 samples of +1000 with in_sof on the first, out_ready=1 ->
//     out_data = 0,10,38,84,146,222,309,402,500,598,691,778,854,916,962,990,1000, mirrored;
//     out_sof on #0, out_last on #31, first out_valid 2 cycles after first accept.
//  2. Frame of -1000 -> index 8 gives -500, index 16 gives -1000, index 1 gives -10;
//     frame of -2048 at index 16 gives -2048 and +2047 gives 2047 (no overflow).
//  3. out_ready toggled pseudo-randomly, in_valid with random gaps over 4 frames ->
//     output sequence equals the ideal model exactly; out_data is stable during stalls.
//  4. Back-to-back frames, in_sof only on first -> index wraps 31->0;
//     second frame output identical to first; frame_err never asserts.
//  5. in_sof asserted on the 10th sample of a frame -> frame_err pulses once;
//     that sample is windowed with w[0] (out 0) and out_sof=1; following samples use w[1], w[2], ...
//  6. rst_n pulsed low mid-frame with the pipeline full -> out_valid=0 immediately (async);
//     after release, the next sample without in_sof uses index 0.

Source files
------------

// File: rtl/hann32_apply_if.sv
// Stream bundle for the Hann window stage: sample input side, windowed output side.
interface hann32_apply_if #(parameter int DATA_W = 12);
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_sof;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_sof;
  logic                     out_last;
  logic                     out_ready;
  logic                     frame_err;

  modport slave (
    input  in_data, in_valid, in_sof, out_ready,
    output in_ready, out_data, out_valid, out_sof, out_last, frame_err
  );

  modport master (
    output in_data, in_valid, in_sof, out_ready,
    input  in_ready, out_data, out_valid, out_sof, out_last, frame_err
  );
endinterface

// File: rtl/hann32_apply.sv
// 32-point Hann window applied to a framed signed stream; 2-stage pipeline,
// out = round_half_up(x * w[k] / 2048) with Q1.11 coefficients.
module hann32_apply #(
  parameter int DATA_W = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  hann32_apply_if.slave bus
);
  localparam int N  = 32;
  localparam int PW = 2*DATA_W + 1;

  // Half table; the upper half mirrors around k=16 (w[k] = w[32-k]).
  function automatic logic [11:0] f_coef(input logic [4:0] k);
    logic [4:0] f;
    f = (k > 5'd16) ? (5'd0 - k) : k;
    case (f)
      5'd0:    f_coef = 12'd0;
      5'd1:    f_coef = 12'd20;
      5'd2:    f_coef = 12'd78;
      5'd3:    f_coef = 12'd173;
      5'd4:    f_coef = 12'd300;
      5'd5:    f_coef = 12'd455;
      5'd6:    f_coef = 12'd632;
      5'd7:    f_coef = 12'd824;
      5'd8:    f_coef = 12'd1024;
      5'd9:    f_coef = 12'd1224;
      5'd10:   f_coef = 12'd1416;
      5'd11:   f_coef = 12'd1593;
      5'd12:   f_coef = 12'd1748;
      5'd13:   f_coef = 12'd1875;
      5'd14:   f_coef = 12'd1970;
      5'd15:   f_coef = 12'd2028;
      default: f_coef = 12'd2048;
    endcase
  endfunction

  logic                     w_adv, w_acc;
  logic [4:0]               w_k;
  logic [4:0]               r_idx;
  logic [2:1]               r_vld_pipe;
  logic signed [DATA_W-1:0] r_s1_x;
  logic [11:0]              r_s1_w;
  logic                     r_s1_sof, r_s1_last;
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_out_sof, r_out_last, r_ferr;
  logic signed [PW-1:0]     w_x_ext, w_w_ext, w_p, w_rnd;

  assign w_adv = !r_vld_pipe[2] || bus.out_ready;
  assign w_acc = bus.in_valid && w_adv;
  assign w_k   = bus.in_sof ? 5'd0 : r_idx;

  // Operands widened to the full product width so the multiply is exact.
  assign w_x_ext = PW'(r_s1_x);
  assign w_w_ext = PW'({1'b0, r_s1_w});
  assign w_p     = w_x_ext * w_w_ext;
  assign w_rnd   = (w_p + PW'(1024)) >>> 11;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_ferr <= 1'b0;
    end else begin
      r_ferr <= w_acc && bus.in_sof && (r_idx != 5'd0);
      if (w_acc) r_idx <= w_k + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_s1_x     <= '0;
      r_s1_w     <= '0;
      r_s1_sof   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_out_data <= '0;
      r_out_sof  <= 1'b0;
      r_out_last <= 1'b0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[1], bus.in_valid};
      r_s1_x     <= bus.in_data;
      r_s1_w     <= f_coef(w_k);
      r_s1_sof   <= (w_k == 5'd0);
      r_s1_last  <= (w_k == 5'(N-1));
      r_out_data <= DATA_W'(w_rnd);
      r_out_sof  <= r_s1_sof;
      r_out_last <= r_s1_last;
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_vld_pipe[2];
  assign bus.out_sof   = r_out_sof;
  assign bus.out_last  = r_out_last;
  assign bus.frame_err = r_ferr;
endmodule

// File: tb/tb_hann32_apply.sv
// Bench for hann32_apply: constant tables, hand sequences for latency/resync/reset,
// and a randomized backpressure run against an arithmetic reference model.
module tb_hann32_apply;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hann32_apply_if #(.DATA_W(12)) bus ();
  hann32_apply #(.DATA_W(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct { int d; bit s; bit l; } item_t;
  typedef struct { logic signed [11:0] x; bit sof; int exp; bit exp_sof; bit exp_last; } vec_t;

  int n_err = 0, n_chk = 0, ferr_cnt = 0;
  bit rnd_mode = 0;
  item_t expq[$];
  item_t obs[$];
  vec_t  tbl[96];
  int    W[17] = '{0,20,78,173,300,455,632,824,1024,1224,1416,1593,1748,1875,1970,2028,2048};
  int    E[17] = '{0,10,38,84,146,222,309,402,500,598,691,778,854,916,962,990,1000};

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int coef(input int k);
    return (k <= 16) ? W[k] : W[32-k];
  endfunction

  // Reference: ideal rounding of x*w/2048, half toward +inf, in real arithmetic.
  function automatic int model_out(input int x, input int k);
    return int'($floor(real'(x) * real'(coef(k)) / 2048.0 + 0.5));
  endfunction

  // Monitor/model: samples on the falling edge, transfers happen on the next rising edge.
  initial begin
    int m_idx, k;
    bit pend, new_pend, prev_stall;
    item_t prev, it, e;
    m_idx = 0; pend = 0; prev_stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expq.delete(); m_idx = 0; pend = 0; prev_stall = 0;
      end else begin
        check("frame_err", int'(bus.frame_err), int'(pend));
        if (bus.frame_err) ferr_cnt++;
        if (prev_stall) begin
          check("stall_valid", int'(bus.out_valid), 1);
          check("stall_data", int'($signed(bus.out_data)), prev.d);
          check("stall_sof", int'(bus.out_sof), int'(prev.s));
          check("stall_last", int'(bus.out_last), int'(prev.l));
        end
        if (bus.out_valid && bus.out_ready) begin
          it = '{int'($signed(bus.out_data)), bus.out_sof, bus.out_last};
          obs.push_back(it);
          if (expq.size() == 0) check("unexpected_output", 1, 0);
          else begin
            e = expq.pop_front();
            check("model_data", it.d, e.d);
            check("model_sof", int'(it.s), int'(e.s));
            check("model_last", int'(it.l), int'(e.l));
          end
        end
        new_pend = 0;
        if (bus.in_valid && bus.in_ready) begin
          k = bus.in_sof ? 0 : m_idx;
          if (bus.in_sof && m_idx != 0) new_pend = 1;
          expq.push_back('{model_out(int'(bus.in_data), k), k == 0, k == 31});
          m_idx = (k + 1) % 32;
        end
        pend = new_pend;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev = '{int'($signed(bus.out_data)), bus.out_sof, bus.out_last};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_mode) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic signed [11:0] x, input bit sof);
    int n = 0;
    bit acc = 0;
    bus.in_data = x; bus.in_sof = sof; bus.in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1; n++;
    end
    if (!acc) check("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_sof = 1'($urandom_range(0, 1));
    bus.in_data = 12'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 1000) begin @(posedge clk); n++; end
    if (expq.size() != 0) check("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int kk, e5[12], s5[12], f0;
    bus.in_valid = 0; bus.in_sof = 0; bus.in_data = '0; bus.out_ready = 1;

    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 32; k++) begin
        kk = (k <= 16) ? k : 32 - k;
        tbl[f*32+k].x        = (f == 1) ? -12'sd1000 : 12'sd1000;
        tbl[f*32+k].exp      = (f == 1) ? -E[kk] : E[kk];
        tbl[f*32+k].sof      = (f == 0 && k == 0);
        tbl[f*32+k].exp_sof  = (k == 0);
        tbl[f*32+k].exp_last = (k == 31);
        if (k == 16 && f == 1) begin tbl[f*32+k].x = -12'sd2048; tbl[f*32+k].exp = -2048; end
        if (k == 16 && f == 2) begin tbl[f*32+k].x = 12'sd2047;  tbl[f*32+k].exp = 2047;  end
      end

    // Reset state
    #3;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_sof", int'(bus.out_sof), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_frame_err", int'(bus.frame_err), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    do_reset();

    // Latency: one sample, output valid exactly two cycles after presentation
    send(12'sd1000, 1'b1);
    @(negedge clk);
    check("lat_cycle1_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    check("lat_cycle2_valid", int'(bus.out_valid), 1);
    check("lat_cycle2_sof", int'(bus.out_sof), 1);
    check("lat_cycle2_data", int'($signed(bus.out_data)), 0);
    @(posedge clk); #1;
    do_reset();

    // Table: three back-to-back frames, in_sof only on the very first sample
    obs.delete(); f0 = ferr_cnt;
    foreach (tbl[i]) send(tbl[i].x, tbl[i].sof);
    drain();
    check("tbl_count", obs.size(), 96);
    if (obs.size() == 96)
      foreach (tbl[i]) begin
        check($sformatf("tbl_data[%0d]", i), obs[i].d, tbl[i].exp);
        check($sformatf("tbl_sof[%0d]", i), int'(obs[i].s), int'(tbl[i].exp_sof));
        check($sformatf("tbl_last[%0d]", i), int'(obs[i].l), int'(tbl[i].exp_last));
      end
    check("tbl_no_frame_err", ferr_cnt - f0, 0);

    // Early in_sof on the 10th sample of a frame
    obs.delete(); f0 = ferr_cnt;
    for (int i = 0; i < 12; i++) begin
      send(12'sd1000, i == 0 || i == 9);
      e5[i] = (i < 9) ? E[i] : (i == 9 ? 0 : E[i-9]);
      s5[i] = (i == 0 || i == 9);
    end
    drain();
    check("resync_count", obs.size(), 12);
    if (obs.size() == 12)
      for (int i = 0; i < 12; i++) begin
        check($sformatf("resync_data[%0d]", i), obs[i].d, e5[i]);
        check($sformatf("resync_sof[%0d]", i), int'(obs[i].s), s5[i]);
      end
    check("resync_frame_err_pulses", ferr_cnt - f0, 1);

    // Random gaps and backpressure over four frames
    obs.delete(); rnd_mode = 1;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 32; k++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        send(12'($urandom), k == 0);
      end
    drain();
    rnd_mode = 0; bus.out_ready = 1;
    #1;
    check("rand_count", obs.size(), 128);

    // Async reset with the pipeline full and stalled
    bus.out_ready = 0;
    send(12'sd1000, 1'b1);
    send(12'sd1000, 1'b0);
    @(negedge clk);
    check("full_out_valid", int'(bus.out_valid), 1);
    check("full_in_ready", int'(bus.in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", int'(bus.out_valid), 0);
    check("async_out_data", int'(bus.out_data), 0);
    check("async_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    #2 rst_n = 1'b1; bus.out_ready = 1;
    @(posedge clk); #1;
    obs.delete();
    send(12'sd1000, 1'b0);
    drain();
    check("post_rst_count", obs.size(), 1);
    if (obs.size() == 1) begin
      check("post_rst_data", obs[0].d, 0);
      check("post_rst_sof", int'(obs[0].s), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
